add_compare_datapath: RTL and testbench
=======================================

ADD_COMPARE_DATAPATH -- requirements
Module: add_compare_datapath

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, the operand width in bits.
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-005 in_ready  output  1  the operand buffer can accept a pair.
REQ-006 in_a  input  WIDTH  first operand.
REQ-007 in_b  input  WIDTH  second operand.
REQ-008 limit  input  WIDTH+1  compare threshold, sampled in the cycle s=1.
REQ-009 we  input  1  control-unit write strobe: add the buffered operands into sum.
REQ-010 s  input  1  control-unit select strobe: compare sum against limit.
REQ-011 x  output  1  registered compare flag, 1 = sum < limit (control unit branches to SMALL), 0 = LARGE.
REQ-012 x_valid  output  1  x reflects the current sum.
REQ-013 sum  output  WIDTH+1  registered sum.
REQ-014 op_count  output  8  count of successful writes.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 The operand buffer SHALL hold one pair; in_ready SHALL equal NOT buf_full, combinationally.
REQ-017 On in_valid=1 and in_ready=1 at a rising edge, the block SHALL capture in_a/in_b and set buf_full.
REQ-018 On we=1 with buf_full=1, the block SHALL load sum with zero-extended a_buf + b_buf (WIDTH+1 bits, no overflow loss), clear buf_full, clear x_valid, and increment op_count, all at the same edge.
REQ-019 op_count SHALL wrap from 255 to 0 without flagging an error.
REQ-020 On we=1 with buf_full=0, the block SHALL leave sum, x, x_valid and op_count unchanged and set err.
REQ-021 On s=1 with we=0, the block SHALL register x = (sum < limit) as an unsigned compare using the current sum and set x_valid, one cycle latency.
REQ-022 On s=1 with x_valid=0 and no prior write since reset, the block SHALL still compare, using sum=0.
REQ-023 On we=1 and s=1 in the same cycle, we SHALL take effect per REQ-018/REQ-020, s SHALL be ignored, x_valid SHALL end 0, and err SHALL be set.
REQ-024 When buf_full=1 and we=1 consume the buffer, in_ready SHALL stay 0 in that cycle (no same-cycle refill); in_ready SHALL be 1 from the next cycle.
REQ-025 x and x_valid SHALL hold their values until the next compare, the next successful write, or reset.
REQ-026 err SHALL be cleared only by reset.

Reset
REQ-027 While reset_n=0, the block SHALL drive sum=0, x=0, x_valid=0, op_count=0 and err=0, clear buf_full (in_ready=1), and do so asynchronously without waiting for a CLK edge.
REQ-028 Reset asserted mid-operation SHALL discard a buffered operand pair and any pending compare result.
REQ-029 After reset_n rises, the first rising edge SHALL be able to accept a handshake.

Verification
REQ-030 Basic add-compare: reset; pair (5,7) accepted; we=1; s=1 with limit=13 -> sum=12, x=1, x_valid=1, op_count=1, err=0.
REQ-031 Width boundary (WIDTH=8): pair (255,255); we; s with limit=510 -> sum=510, x=0; s with limit=511 -> x=1.
REQ-032 Protocol errors: we=1 with the buffer empty -> sum unchanged and err=1. Then load a pair and pulse we=1, s=1 together -> sum updates, x_valid=0, err stays 1.
REQ-033 Backpressure: in_valid held high with a new pair each cycle and we pulsed every third cycle -> exactly one pair accepted per consumption, in_ready=0 while full, no pair lost or duplicated.
REQ-034 Reset mid-operation: pair buffered, x_valid=1, then reset_n low between edges -> all outputs 0 and in_ready=1 immediately; 256 successful writes -> op_count wraps to 0.

Source files
------------

// File: rtl/add_compare_datapath.sv
// One-pair operand buffer feeding a registered WIDTH+1 bit adder and an unsigned
// less-than compare, driven by we/s strobes from an external control unit.
module add_compare_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   limit,
    input  logic             we,
    input  logic             s,
    output logic             x,
    output logic             x_valid,
    output logic [WIDTH:0]   sum,
    output logic [7:0]       op_count,
    output logic             err
);

    // Handshake: a pair transfers on a rising edge where in_valid and in_ready are both 1.
    // in_ready depends only on buf_full, so a consuming write never refills in the same cycle.
    logic             buf_full;
    logic [WIDTH-1:0] a_buf;
    logic [WIDTH-1:0] b_buf;

    logic accept;
    logic write_ok;
    logic write_bad;
    logic collide;

    assign in_ready  = ~buf_full;
    assign accept    = in_valid & ~buf_full;
    assign write_ok  = we & buf_full;
    assign write_bad = we & ~buf_full;
    assign collide   = we & s;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            buf_full <= 1'b0;
            a_buf    <= '0;
            b_buf    <= '0;
        end else if (write_ok) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            a_buf    <= in_a;
            b_buf    <= in_b;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sum      <= '0;
            op_count <= '0;
        end else if (write_ok) begin
            sum      <= {1'b0, a_buf} + {1'b0, b_buf};
            op_count <= op_count + 8'd1;
        end
    end

    // A we/s collision always leaves x_valid low, even if the write itself was rejected.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            x       <= 1'b0;
            x_valid <= 1'b0;
        end else if (write_ok || collide) begin
            x_valid <= 1'b0;
        end else if (s && !we) begin
            x       <= (sum < limit);
            x_valid <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (write_bad || collide) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_add_compare_datapath.sv
// Randomized and directed bench for add_compare_datapath, checked against a
// transaction-level model: a queue of accepted pair sums plus scalar result state.
module tb_add_compare_datapath;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   limit;
  logic             we;
  logic             s;
  logic             x;
  logic             x_valid;
  logic [WIDTH:0]   sum;
  logic [7:0]       op_count;
  logic             err;

  add_compare_datapath #(.WIDTH(WIDTH)) dut (
    .CLK      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .limit    (limit),
    .we       (we),
    .s        (s),
    .x        (x),
    .x_valid  (x_valid),
    .sum      (sum),
    .op_count (op_count),
    .err      (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: sums of accepted pairs not yet written
  logic [WIDTH:0] exp_q[$];
  int             m_sum;
  int             m_cnt;
  bit             m_x;
  bit             m_xv;
  bit             m_err;
  int             n_checks;
  int             n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_x   = 0;
    m_xv  = 0;
    m_err = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sum"},      32'(sum),      32'(m_sum));
    check({tag, ".x"},        32'(x),        32'(m_x));
    check({tag, ".x_valid"},  32'(x_valid),  32'(m_xv));
    check({tag, ".op_count"}, 32'(op_count), 32'(m_cnt));
    check({tag, ".err"},      32'(err),      32'(m_err));
  endtask

  // driver: called just after a rising edge; applies inputs for one cycle
  task automatic step(input string tag, input logic v, input int a, input int b,
                      input int lim, input logic w, input logic sel);
    bit full;
    in_valid = v;
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    limit    = (WIDTH+1)'(lim);
    we       = w;
    s        = sel;
    full     = (exp_q.size() != 0);
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!full));
    @(posedge clk);
    if (w && (!full || sel)) m_err = 1;
    if (w && full) begin
      m_sum = int'(exp_q.pop_front());
      m_cnt = (m_cnt + 1) % 256;
      m_xv  = 0;
    end else if (w && sel) begin
      m_xv = 0;
    end else if (sel) begin
      m_x  = (m_sum < lim);
      m_xv = 1;
    end
    if (v && !full) exp_q.push_back((WIDTH+1)'(a + b));
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check_all("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    in_valid = 0; in_a = 0; in_b = 0; limit = 0; we = 0; s = 0;
    reset_n  = 1'b1;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check("por.in_ready", 32'(in_ready), 32'd1);
    check_all("por");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // basic add-compare, first edge after reset accepts the pair
    step("basic.load", 1, 5, 7, 0, 0, 0);
    step("basic.we",   0, 0, 0, 0, 1, 0);
    step("basic.s",    0, 0, 0, 13, 0, 1);
    check("basic.sum12", 32'(sum), 32'd12);
    check("basic.x1",    32'(x),   32'd1);

    // compare with no prior write after reset uses sum=0
    do_reset();
    step("zero.s", 0, 0, 0, 0, 0, 1);
    check("zero.x_lim0", 32'(x), 32'd0);
    step("zero.s1", 0, 0, 0, 1, 0, 1);
    check("zero.x_lim1", 32'(x), 32'd1);

    // width boundary
    step("wb.load", 1, 255, 255, 0, 0, 0);
    step("wb.we",   0, 0, 0, 0, 1, 0);
    check("wb.sum510", 32'(sum), 32'd510);
    step("wb.s510", 0, 0, 0, 510, 0, 1);
    check("wb.x_510", 32'(x), 32'd0);
    step("wb.s511", 0, 0, 0, 511, 0, 1);
    check("wb.x_511", 32'(x), 32'd1);
    idle("wb.hold");

    // protocol errors
    do_reset();
    step("pe.we_empty", 0, 0, 0, 0, 1, 0);
    check("pe.err", 32'(err), 32'd1);
    step("pe.load", 1, 20, 30, 0, 0, 0);
    step("pe.we_s", 0, 0, 0, 100, 1, 1);
    check("pe.sum50", 32'(sum), 32'd50);
    check("pe.xv0",   32'(x_valid), 32'd0);
    step("pe.s_ok", 0, 0, 0, 40, 0, 1);
    step("pe.we_s_empty", 0, 0, 0, 40, 1, 1);

    // backpressure: new pair every cycle, write every third cycle
    do_reset();
    for (int i = 0; i < 18; i++)
      step("bp", 1, $urandom_range(0, 255), $urandom_range(0, 255), 0, (i % 3) == 2, 0);
    check("bp.count6", 32'(op_count), 32'd6);

    // reset mid-operation: buffered pair and valid compare are discarded
    step("mid.s", 0, 0, 0, 300, 0, 1);
    step("mid.load", 1, 9, 9, 0, 0, 0);
    do_reset();
    step("mid.we_after", 0, 0, 0, 0, 1, 0);
    check("mid.err_set", 32'(err), 32'd1);

    // op_count wrap after 256 writes
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step("wrap.load", 1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0);
      step("wrap.we", 0, 0, 0, 0, 1, 0);
    end
    check("wrap.count0", 32'(op_count), 32'd0);
    check("wrap.err0",   32'(err),      32'd0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 511), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
